// File: rtl/fb_scanout_if.sv
// Scanout bus: frame control, BRAM read port and RGB565 pixel stream.
// "master" is the scanout reader; "slave" is the BRAM/sink/controller side.
interface fb_scanout_if #(
   parameter int AW = 15
);
   logic          start;
   logic          busy;
   logic          frame_done;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic [15:0]   px_data;
   logic          px_valid;
   logic          px_ready;
   logic          px_eol;
   logic          px_last;

   modport master (
      input  start, rd_data, px_ready,
      output busy, frame_done, rd_addr, px_data, px_valid, px_eol, px_last
   );

   modport slave (
      output start, rd_data, px_ready,
      input  busy, frame_done, rd_addr, px_data, px_valid, px_eol, px_last
   );
endinterface

// File: rtl/fb_scanout.sv
// Frame-buffer scanout reader: reads RGB332 pixels from a synchronous-read
// BRAM in raster order, expands them to RGB565 and streams them out over
// valid/ready with end-of-line and end-of-frame flags. A one-entry skid
// buffer behind the output register keeps full throughput under backpressure
// while never holding more than two pixels in flight.
module fb_scanout #(
   parameter int H_RES = 160,
   parameter int V_RES = 80,
   parameter int LEN   = H_RES * V_RES
) (
   input  logic         clk,
   input  logic         rst,
   fb_scanout_if.master bus
);
   localparam int AW = $clog2(LEN) + 1;
   localparam int CW = $clog2(H_RES + 1);
   localparam int RW = $clog2(V_RES + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state;
   logic [AW-1:0] addr;
   logic          pend;       // a read was issued last edge; rd_data is valid now
   logic          busy_r;
   logic          done_r;

   logic          out_v, out_eol, out_last;
   logic [15:0]   out_d;
   logic          sk_v, sk_eol, sk_last;
   logic [15:0]   sk_d;

   logic [CW-1:0] col;
   logic [RW-1:0] row;

   logic          hs;
   logic [1:0]    occ;
   logic          issue;
   logic [15:0]   in_d;
   logic          in_eol, in_last;

   function automatic logic [15:0] rgb565(input logic [7:0] d);
      return {d[7:5], d[7:6], d[4:2], d[4:2], d[1:0], d[1:0], d[1]};
   endfunction

   assign hs      = out_v & bus.px_ready;
   // Pixels held or in flight; a new read is allowed only if, after this
   // edge, there is still room for the data it returns.
   assign occ     = {1'b0, out_v} + {1'b0, sk_v} + {1'b0, pend};
   assign issue   = (state == RUN) && ((occ < 2'd2) || (occ == 2'd2 && hs));

   assign in_d    = rgb565(bus.rd_data);
   assign in_eol  = (col == CW'(H_RES - 1));
   assign in_last = in_eol && (row == RW'(V_RES - 1));

   assign bus.rd_addr    = addr;
   assign bus.busy       = busy_r;
   assign bus.frame_done = done_r;
   assign bus.px_valid   = out_v;
   assign bus.px_data    = out_d;
   assign bus.px_eol     = out_eol;
   assign bus.px_last    = out_last;

   // Frame FSM: address issue, busy ownership and the done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         addr   <= '0;
         pend   <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         pend   <= issue;
         done_r <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               state  <= RUN;
               addr   <= '0;
               busy_r <= 1'b1;
            end
            RUN: if (issue) begin
               // Address stays at LEN-1 once the last read is out.
               if (addr == AW'(LEN - 1)) state <= DRAIN;
               else                      addr  <= addr + 1'b1;
            end
            DRAIN: if (hs && out_last) begin
               state  <= DONE;
               done_r <= 1'b1;
            end
            DONE: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output register + skid entry, and raster position of incoming pixels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_v    <= 1'b0;
         out_d    <= '0;
         out_eol  <= 1'b0;
         out_last <= 1'b0;
         sk_v     <= 1'b0;
         sk_d     <= '0;
         sk_eol   <= 1'b0;
         sk_last  <= 1'b0;
         col      <= '0;
         row      <= '0;
      end else begin
         if (state == IDLE && bus.start) begin
            col <= '0;
            row <= '0;
         end else if (pend) begin
            if (in_eol) begin
               col <= '0;
               row <= in_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end

         if (!out_v || hs) begin
            if (sk_v) begin
               out_v    <= 1'b1;
               out_d    <= sk_d;
               out_eol  <= sk_eol;
               out_last <= sk_last;
               sk_v     <= pend;
               if (pend) begin
                  sk_d    <= in_d;
                  sk_eol  <= in_eol;
                  sk_last <= in_last;
               end
            end else if (pend) begin
               out_v    <= 1'b1;
               out_d    <= in_d;
               out_eol  <= in_eol;
               out_last <= in_last;
            end else begin
               out_v    <= 1'b0;
            end
         end else if (pend) begin
            // Output is stalled: park the arriving pixel in the skid entry.
            sk_v    <= 1'b1;
            sk_d    <= in_d;
            sk_eol  <= in_eol;
            sk_last <= in_last;
         end
      end
   end
endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout on an 8x4 geometry with a BRAM model.
module tb_fb_scanout;
   localparam int H   = 8;
   localparam int V   = 4;
   localparam int LEN = H * V;
   localparam int AW  = $clog2(LEN) + 1;

   typedef struct {
      logic [7:0]  din;
      logic [15:0] exp;
   } conv_t;

   typedef struct {
      logic [15:0] d;
      logic        eol;
      logic        last;
   } px_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] mem [0:(1<<AW)-1];

   fb_scanout_if #(.AW(AW)) bus();
   fb_scanout #(.H_RES(H), .V_RES(V)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

   int checks = 0, failures = 0;
   int cyc = 0, mode = 0;
   int fd_cnt = 0, fd_cyc = 0, busy_cnt = 0, gap_cnt = 0, addr_max = 0;
   int e0 = 0;
   px_t got[$];
   px_t refq[$];
   conv_t ctab[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] model(input logic [7:0] d);
      int r, g, b;
      logic [4:0] r5;
      logic [5:0] g6;
      logic [4:0] b5;
      r  = int'(d[7:5]);
      g  = int'(d[4:2]);
      b  = int'(d[1:0]);
      r5 = 5'((r << 2) | (r >> 1));
      g6 = 6'((g << 3) | g);
      b5 = 5'((b << 3) | (b << 1) | (b >> 1));
      return {r5, g6, b5};
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Ready driver: 0 = always ready, 1 = ready ~30% of cycles, 2 = toggling.
   initial begin
      bus.px_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0:       bus.px_ready = 1'b1;
            1:       bus.px_ready = ($urandom_range(0, 99) < 30);
            default: bus.px_ready = ~bus.px_ready;
         endcase
      end
   end

   // Monitor: collect handshakes, verify hold-while-stalled, count events.
   initial begin
      logic pv_q, hs_q;
      px_t  p_q;
      pv_q = 1'b0;
      hs_q = 1'b0;
      p_q  = '{16'h0, 1'b0, 1'b0};
      forever begin
         @(negedge clk);
         if (rst) begin
            pv_q = 1'b0;
         end else begin
            if (pv_q && !hs_q) begin
               check("valid_hold", 32'(bus.px_valid), 32'd1);
               check("data_hold", {14'd0, bus.px_data, bus.px_eol, bus.px_last},
                     {14'd0, p_q.d, p_q.eol, p_q.last});
            end
            pv_q = bus.px_valid;
            p_q  = '{bus.px_data, bus.px_eol, bus.px_last};
            hs_q = bus.px_valid && bus.px_ready;
            if (hs_q) got.push_back(p_q);
            if (bus.frame_done) begin
               fd_cnt++;
               fd_cyc = cyc;
            end
            if (bus.busy) busy_cnt++;
            if (!bus.busy && fd_cnt == 1) gap_cnt++;
            if (int'(bus.rd_addr) > addr_max) addr_max = int'(bus.rd_addr);
         end
      end
   end

   task automatic wait_fd(input int n);
      for (int i = 0; i < 2000 && fd_cnt < n; i++) begin
         @(posedge clk);
         #1;
      end
      check("frame_done_seen", 32'(fd_cnt >= n), 32'd1);
   endtask

   task automatic run_frame(input int md);
      got.delete();
      fd_cnt   = 0;
      busy_cnt = 0;
      mode     = md;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      e0 = cyc;
      check("busy_after_start", 32'(bus.busy), 32'd1);
      check("addr_after_start", 32'(bus.rd_addr), 32'd0);
      @(posedge clk); #1;
      check("valid_after_e1", 32'(bus.px_valid), 32'd0);
      @(posedge clk); #1;
      check("valid_after_e2", 32'(bus.px_valid), 32'd1);
      wait_fd(1);
      repeat (3) @(posedge clk);
      #1;
      check("frame_done_count", 32'(fd_cnt), 32'd1);
      check("pixel_count", 32'(got.size()), 32'(LEN));
      check("valid_idle", 32'(bus.px_valid), 32'd0);
      check("busy_idle", 32'(bus.busy), 32'd0);
      if (md == 0) begin
         check("done_latency", 32'(fd_cyc - e0), 32'(LEN + 2));
         check("busy_cycles", 32'(busy_cnt), 32'(LEN + 3));
      end
   endtask

   task automatic compare_ref(input string tag);
      check({tag, "_size"}, 32'(got.size()), 32'(refq.size()));
      for (int i = 0; i < LEN && i < got.size(); i++)
         check({tag, "_px"}, {14'd0, got[i].d, got[i].eol, got[i].last},
               {14'd0, refq[i].d, refq[i].eol, refq[i].last});
   endtask

   initial begin
      ctab[0] = '{8'h00, 16'h0000};
      ctab[1] = '{8'hE0, 16'hF800};
      ctab[2] = '{8'h1C, 16'h07E0};
      ctab[3] = '{8'h03, 16'h001F};
      ctab[4] = '{8'hFF, 16'hFFFF};
      ctab[5] = '{8'h92, 16'h9495};
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i);
      for (int i = 0; i < 6; i++) mem[i] = ctab[i].din;
      bus.start = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_flags", {27'd0, bus.busy, bus.frame_done, bus.px_valid, bus.px_eol, bus.px_last}, 32'd0);
      check("rst_px_data", 32'(bus.px_data), 32'd0);
      check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);

      // Full frame, always ready: start on the first edge after release
      @(negedge clk);
      rst = 1'b0;
      run_frame(0);
      for (int i = 0; i < got.size(); i++) begin
         if (i < 6) check("conv_table", 32'(got[i].d), 32'(ctab[i].exp));
         else       check("conv_model", 32'(got[i].d), 32'(model(8'(i))));
         check("eol_flag", 32'(got[i].eol), 32'((i % H) == H - 1));
         check("last_flag", 32'(got[i].last), 32'(i == LEN - 1));
      end
      refq = got;

      // Random backpressure
      run_frame(1);
      compare_ref("bp");

      // Start pulsed mid-frame and during DONE, ready toggling
      got.delete();
      fd_cnt = 0;
      mode = 2;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 500 && got.size() < 10; i++) begin
         @(posedge clk); #1;
      end
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 500 && !bus.frame_done; i++) begin
         @(posedge clk); #1;
      end
      check("done_pulse_seen", 32'(bus.frame_done), 32'd1);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("ignored_start_frames", 32'(fd_cnt), 32'd1);
      check("ignored_start_busy", 32'(bus.busy), 32'd0);
      compare_ref("toggle");

      // Start held: back-to-back frames with one idle cycle
      got.delete();
      fd_cnt = 0;
      gap_cnt = 0;
      mode = 0;
      bus.start = 1'b1;
      wait_fd(2);
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("b2b_pixels", 32'(got.size()), 32'(2 * LEN));
      check("b2b_idle_gap", 32'(gap_cnt), 32'd1);
      check("b2b_frames", 32'(fd_cnt), 32'd2);

      // Asynchronous reset mid-frame, then a clean restart from address 0
      got.delete();
      mode = 0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 500 && got.size() < 12; i++) begin
         @(posedge clk); #1;
      end
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_flags", {27'd0, bus.busy, bus.frame_done, bus.px_valid, bus.px_eol, bus.px_last}, 32'd0);
      check("async_rst_px_data", 32'(bus.px_data), 32'd0);
      check("async_rst_rd_addr", 32'(bus.rd_addr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_frame(0);
      compare_ref("after_rst");

      check("addr_max", 32'(addr_max), 32'(LEN - 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fb_scanout.md
# fb_scanout

Frame-buffer scanout reader for the LCD display-buffer path. It reads an entire frame of RGB332 pixels, 160×80 by default, from the single-port synchronous-read display BRAM in raster order. It expands each pixel to RGB565 and streams it over a valid/ready interface toward the LCD serializer. It owns the BRAM address port only while `busy` is high; the writer owns it otherwise.

## Interface

- `H_RES`, 160, pixels per line.
- `V_RES`, 80, lines per frame.
- `LEN`, `H_RES*V_RES`, buffer depth in pixels.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begin one frame; sampled only in IDLE.
- `busy`  out  1  high from the start-accept edge through DONE; selects this block on the BRAM address mux.
- `frame_done`  out  1  one-cycle pulse after the last pixel handshake.
- `rd_addr`  out  AW  BRAM address. AW = (number of bits to represent LEN-1) + 1, which is 15 for 12800.
- `rd_data`  in  8  BRAM read data, valid one cycle after `rd_addr`; format RRRGGGBB.
- `px_data`  out  16  RGB565 pixel.
- `px_valid`  out  1  pixel available.
- `px_ready`  in  1  sink accepts; a handshake occurs when `px_valid` and `px_ready` are both high on an edge.
- `px_eol`  out  1  qualifies `px_data`: last pixel of a line.
- `px_last`  out  1  qualifies `px_data`: last pixel of the frame.

## Operation

- States:
  - IDLE: on `start`, go to RUN.
  - RUN: read addresses 0..LEN-1. After address LEN-1 is issued, go to DRAIN.
  - DRAIN: once the pixel for address LEN-1 has been handshaked, go to DONE.
  - DONE: one cycle, then IDLE.
- Read issue: a new address is issued only when the output register plus the skid entry can absorb it. At most two pixels are in flight or held.
- Output behaviour:
  - No pixel may be dropped or duplicated under any `px_ready` pattern.
  - Once `px_valid` rises, it stays high until the handshake.
  - `px_data`, `px_eol` and `px_last` are stable while stalled.
- Conversion, with r = d[7:5], g = d[4:2], b = d[1:0]: R5 = {r, r[2:1]}, G6 = {g, g}, B5 = {b, b, b[1]}. Examples: 0xFF→0xFFFF, 0xE0→0xF800, 0x1C→0x07E0, 0x03→0x001F, 0x92→0x9495.
- Flags, tracked with column and row counters (wrap at H_RES-1 and V_RES-1):
  - `px_eol` is set when column = H_RES-1.
  - `px_last` is set when column = H_RES-1 and row = V_RES-1.
- `start` is ignored outside IDLE; no queueing. If `start` is held high, a new frame begins on the edge after DONE.
- The block never writes the BRAM and has no `we` output.
- Reset value of every output:
  - `rd_addr` = 0, `px_data` = 0.
  - `px_valid`, `px_eol`, `px_last`, `busy`, `frame_done` = 0.
  - FSM in IDLE, counters 0.

## Timing

- With `start` sampled at edge E0:
  - `busy` is high after E0.
  - `rd_addr` = 0 after E0.
  - `px_valid` first rises after E0+2 (registered output).
- With `px_ready` held at 1, pixel k is presented after E0+2+k: one pixel per cycle, with no bubbles.
- A stall of S cycles delays all later pixels by exactly S. After `px_ready` rises again, throughput recovers to 1 per cycle without a bubble.
- Last handshake at edge H:
  - DONE after H, `frame_done` = 1 for exactly that cycle.
  - `busy` drops after H+1.
  - `px_valid` = 0 after H unless a new frame is running.
- `rst` asserted mid-frame: all outputs take their reset values immediately (asynchronously), and the frame is abandoned. The next `start` restarts from address 0, row 0, column 0.
- `rst` release is synchronous to `clk`; `start` on the first edge after release is honoured.

## Test plan

- Reset: assert `rst` at random cycle with frame active → all outputs 0 within same cycle; after release plus `start`, first pixel is from address 0.
- Full frame with ready=1, BRAM preloaded mem[i]=i[7:0]:
  - 12800 pixels, each equal to the conversion of i mod 256 (e.g. pixel 0x92 → 0x9495).
  - `px_eol` on every 160th pixel; `px_last` only on pixel 12799.
  - `frame_done` pulses 1 cycle after, and total frame length is 12800+3 cycles from start.
- Random backpressure, ready high 30% of cycles:
  - Received sequence is identical to the ready=1 run.
  - `px_data` and flags are held during every stall, and `px_valid` never drops before its handshake.
- Start control:
  - `start` pulsed at pixel 100 and in DONE → ignored, exactly one frame produced.
  - `start` held high → back-to-back frames with one IDLE cycle between them.
- Small geometry H_RES=4, V_RES=2, ready toggling 1/0: 8 pixels, `px_eol` on pixels 3 and 7, `px_last` on pixel 7, `rd_addr` never exceeds 7.
- Conversion corners: mem values 0x00, 0xE0, 0x1C, 0x03, 0xFF → 0x0000, 0xF800, 0x07E0, 0x001F, 0xFFFF.
